mdu_pipe_sched: RTL and testbench
=================================

Name: mdu_pipe_sched

Overview:
- Scheduler for the multi-cycle multiply/divide unit (MDU) in the 5-stage pipeline.
- Decides when a MULT/DIV in ID is issued, tracks its latency and pulses the HI/LO write at completion.
- Merges MDU structural/data stalls with the external load-use stall and the EX branch-taken flush into one set of pipeline control signals (PC, IF/ID, ID/EX).
- Sits beside the hazard detection unit; its outputs drive PC, IF/ID and ID/EX registers directly.

Parameters:
- MULT_LAT, 4, cycles from issue to HI/LO write for MULT/MULTU; legal range 1..63.
- DIV_LAT, 32, cycles from issue to HI/LO write for DIV/DIVU; legal range 1..63.
- CNT_W, 6, latency counter width; must hold max(MULT_LAT, DIV_LAT)-1.

Ports:
- clk, in, 1, clock, rising edge.
- rst, in, 1, reset: asynchronous, active-high.
- id_mdu_req, in, 1, ID holds a MULT/MULTU/DIV/DIVU.
- id_mdu_div, in, 1, 1 = divide, 0 = multiply; valid with id_mdu_req.
- id_hilo_rd, in, 1, ID holds MFHI/MFLO.
- id_hilo_wr, in, 1, ID holds MTHI/MTLO.
- load_use_stall, in, 1, stall request from the hazard detection unit.
- ex_branch_taken, in, 1, branch/jump resolved taken in EX.
- pc_write, out, 1, PC load enable.
- ifid_write, out, 1, IF/ID load enable.
- ifid_flush, out, 1, IF/ID clear to bubble.
- idex_flush, out, 1, ID/EX clear to bubble.
- mdu_issue, out, 1, one-cycle start strobe to the MDU datapath.
- mdu_busy, out, 1, operation in flight.
- hilo_we, out, 1, one-cycle HI/LO write strobe at completion.
- hilo_fwd, out, 1, select MDU result bypass for MFHI/MFLO (feature only; tied 0 otherwise).

Behaviour:
- State register: IDLE and BUSY, plus cnt[CNT_W-1:0]. Both are async-reset to IDLE and cnt=0.
- Outputs decode combinationally from the state and the current inputs.
- Reset values (rst high): pc_write=1, ifid_write=1, ifid_flush=0, idex_flush=0, mdu_issue=0, mdu_busy=0, hilo_we=0, hilo_fwd=0.
- mdu_busy = (state==BUSY).
- mdu_hz = mdu_busy & (id_mdu_req | id_hilo_rd | id_hilo_wr). This is a structural or HI/LO data hazard.
- stall = load_use_stall | mdu_hz.
- Priority 1, ex_branch_taken=1:
  - ifid_flush=1, idex_flush=1, pc_write=1, ifid_write=1, mdu_issue=0.
  - The flush overrides any stall.
  - An in-flight operation continues unaffected, because it was issued from an older instruction.
- Priority 2, stall=1: pc_write=0, ifid_write=0, idex_flush=1, ifid_flush=0, mdu_issue=0.
- Otherwise: pc_write=1, ifid_write=1, both flushes 0.
- mdu_issue = id_mdu_req & ~stall & ~ex_branch_taken. Only one issue is possible per cycle.
- Issue in IDLE: next state is BUSY, and cnt loads (id_mdu_div ? DIV_LAT : MULT_LAT) - 1.
- In BUSY with cnt!=0: cnt decrements by 1 each cycle.
- In BUSY with cnt==0:
  - hilo_we=1 for that cycle.
  - Next state is IDLE.
  - mdu_busy remains 1 in that cycle, so a dependent instruction stalls through it.
- Latency: issue in cycle t gives hilo_we in cycle t+LAT. The earliest following issue is at t+LAT+1.
- Issue can never occur while BUSY, because mdu_hz blocks it.
- LAT=1: cnt loads 0, so hilo_we falls in the cycle after issue.
- rst asserted mid-operation: state goes to IDLE and cnt to 0 immediately. No hilo_we is produced and the operation is discarded.
- load_use_stall and mdu_hz together: same stall response, counted as one stall.

Optional Feature:
- Macro MDU_HILO_FWD_EN.
- Defined: in the completion cycle (BUSY, cnt==0), an MFHI/MFLO in ID is not counted in mdu_hz and hilo_fwd=1, so the read takes the MDU result bypass and saves one cycle. MULT/DIV/MTHI/MTLO in ID still stall in that cycle. hilo_fwd is 0 in every other cycle.
- Undefined: hilo_fwd is tied 0, and MFHI/MFLO stalls until the cycle after hilo_we.

Test Plan:
- Reset: assert rst mid-clock -> all outputs at their reset values immediately; after release with idle inputs, pc_write=1, ifid_write=1.
- MULT issue with MULT_LAT=4 at cycle 10 -> mdu_issue=1 at 10, mdu_busy=1 in 11..14, hilo_we=1 at 14 only, IDLE at 15.
- MFHI in ID from cycle 11 after a DIV issued at 10 with DIV_LAT=32 -> pc_write=0, ifid_write=0, idex_flush=1 in 11..42; released at 43. With MDU_HILO_FWD_EN, released at 42 with hilo_fwd=1.
- Back-to-back MULTs, both MULT_LAT=4, second MULT in ID at cycle 11 -> second stalls 11..14 and issues at 15 (mdu_issue=1), with hilo_we at 14 and 19.
- ex_branch_taken=1 together with load_use_stall=1 and id_mdu_req=1 in IDLE -> ifid_flush=1, idex_flush=1, pc_write=1, mdu_issue=0, state stays IDLE.
- rst pulsed at cycle 20 during a DIV issued at 10 -> mdu_busy=0 at once, no hilo_we afterwards, and a new MULT issues normally on the first cycle after reset.

Source files
------------

// File: rtl/mdu_pipe_sched.sv
// rtl/mdu_pipe_sched.sv - MULT/DIV issue scheduler and pipeline stall/flush merge
// Optional MFHI/MFLO result bypass in the completion cycle: define MDU_HILO_FWD_EN.
module mdu_pipe_sched #(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 32,
  parameter int CNT_W    = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic id_mdu_req,
  input  logic id_mdu_div,
  input  logic id_hilo_rd,
  input  logic id_hilo_wr,
  input  logic load_use_stall,
  input  logic ex_branch_taken,
  output logic pc_write,
  output logic ifid_write,
  output logic ifid_flush,
  output logic idex_flush,
  output logic mdu_issue,
  output logic mdu_busy,
  output logic hilo_we,
  output logic hilo_fwd
);

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             busy, done, rd_hz, mdu_hz, stall, issue;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    busy = (state == BUSY);
    done = busy && (cnt == '0);
`ifdef MDU_HILO_FWD_EN
    // A read in the completion cycle takes the bypass instead of stalling.
    rd_hz = id_hilo_rd & ~done;
`else
    rd_hz = id_hilo_rd;
`endif
    mdu_hz = busy & (id_mdu_req | rd_hz | id_hilo_wr);
    stall  = load_use_stall | mdu_hz;
    issue  = id_mdu_req & ~stall & ~ex_branch_taken;

    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (issue) begin
          state_nxt = BUSY;
          cnt_nxt   = id_mdu_div ? DIV_CNT : MULT_CNT;
        end
      end
      BUSY: begin
        if (done) state_nxt = IDLE;
        else      cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase

    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    mdu_issue  = 1'b0;
    mdu_busy   = busy;
    hilo_we    = done;
`ifdef MDU_HILO_FWD_EN
    hilo_fwd   = done & id_hilo_rd & ~rst;
`else
    hilo_fwd   = 1'b0;
`endif

    // Branch flush wins over any stall; the in-flight op is older and keeps running.
    if (rst) begin
      mdu_busy = 1'b0;
      hilo_we  = 1'b0;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end else begin
      mdu_issue = issue;
    end
  end

endmodule

// File: tb/tb_mdu_pipe_sched.sv
// tb/tb_mdu_pipe_sched.sv - table, directed and randomized checks for mdu_pipe_sched
module tb_mdu_pipe_sched;

  localparam int ML = 4;
  localparam int DL = 32;
`ifdef MDU_HILO_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, id_mdu_req, id_mdu_div, id_hilo_rd, id_hilo_wr, load_use_stall, ex_branch_taken;
  logic pc_write, ifid_write, ifid_flush, idex_flush, mdu_issue, mdu_busy, hilo_we, hilo_fwd;
  logic [7:0] outv;

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  bit m_active = 1'b0;
  int m_done_at = 0;

  mdu_pipe_sched #(.MULT_LAT(ML), .DIV_LAT(DL), .CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .id_mdu_req(id_mdu_req), .id_mdu_div(id_mdu_div),
    .id_hilo_rd(id_hilo_rd), .id_hilo_wr(id_hilo_wr),
    .load_use_stall(load_use_stall), .ex_branch_taken(ex_branch_taken),
    .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .mdu_issue(mdu_issue), .mdu_busy(mdu_busy),
    .hilo_we(hilo_we), .hilo_fwd(hilo_fwd)
  );

  // Output order: pc_write ifid_write ifid_flush idex_flush mdu_issue mdu_busy hilo_we hilo_fwd
  assign outv = {pc_write, ifid_write, ifid_flush, idex_flush, mdu_issue, mdu_busy, hilo_we, hilo_fwd};

  typedef struct {
    bit req, div, rd, wr, lu, br;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[14];

  task automatic cmp(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b (pw iw iff idf iss busy we fwd)", name, got, exp);
    end
  endtask

  task automatic drive(input bit r, input bit req, input bit div, input bit rd,
                       input bit wr, input bit lu, input bit br);
    rst = r; id_mdu_req = req; id_mdu_div = div; id_hilo_rd = rd;
    id_hilo_wr = wr; load_use_stall = lu; ex_branch_taken = br;
  endtask

  // Reference: an op issued in cycle t is busy in t+1..t+LAT and writes HI/LO at t+LAT.
  task automatic model_step(output logic [7:0] e);
    bit busy, done, hz, stall, iss, fwd;
    if (rst) begin
      e = 8'b1100_0000;
      m_active = 1'b0;
      return;
    end
    busy  = m_active;
    done  = busy && (cyc == m_done_at);
    hz    = busy && (id_mdu_req || id_hilo_wr || (id_hilo_rd && !(FWD && done)));
    stall = load_use_stall || hz;
    iss   = id_mdu_req && !stall && !ex_branch_taken;
    fwd   = FWD && done && id_hilo_rd;
    if (ex_branch_taken) e = {4'b1111, 1'b0, busy, done, fwd};
    else if (stall)      e = {4'b0001, 1'b0, busy, done, fwd};
    else                 e = {4'b1100, iss, busy, done, fwd};
    if (done) m_active = 1'b0;
    if (iss) begin
      m_active  = 1'b1;
      m_done_at = cyc + (id_mdu_div ? DL : ML);
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [7:0] e;
    int t_we;

    tbl[0]  = '{0, 0, 0, 0, 0, 0, 8'b1100_0000};
    tbl[1]  = '{1, 0, 0, 0, 1, 1, 8'b1111_0000};
    tbl[2]  = '{0, 0, 0, 0, 1, 0, 8'b0001_0000};
    tbl[3]  = '{1, 0, 0, 0, 0, 0, 8'b1100_1000};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 8'b1100_0100};
    tbl[5]  = '{1, 0, 0, 0, 0, 0, 8'b0001_0100};
    tbl[6]  = '{1, 0, 0, 0, 0, 1, 8'b1111_0100};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 8'b1100_0110};
    tbl[8]  = '{1, 0, 0, 0, 0, 0, 8'b1100_1000};
    tbl[9]  = '{0, 0, 0, 1, 0, 0, 8'b0001_0100};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 8'b1100_0100};
    tbl[11] = '{0, 0, 1, 0, 0, 0, 8'b0001_0100};
    tbl[12] = '{0, 0, 1, 0, 0, 0, FWD ? 8'b1100_0111 : 8'b0001_0110};
    tbl[13] = '{0, 0, 1, 0, 0, 0, 8'b1100_0000};

    drive(1, 0, 0, 0, 0, 0, 0);
    #1;
    cmp("reset_initial", outv, 8'b1100_0000);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    cmp("after_reset_idle", outv, 8'b1100_0000);

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(0, tbl[i].req, tbl[i].div, tbl[i].rd, tbl[i].wr, tbl[i].lu, tbl[i].br);
      #1;
      cmp($sformatf("tbl[%0d]", i), outv, tbl[i].exp);
    end

    // DIV then MFHI waiting in ID.
    reset_pulse();
    @(negedge clk);
    drive(0, 1, 1, 0, 0, 0, 0);
    #1;
    cmp("div_issue", outv, 8'b1100_1000);
    for (int k = 1; k <= DL; k++) begin
      @(negedge clk);
      drive(0, 0, 0, 1, 0, 0, 0);
      #1;
      if (k == DL) cmp("div_mfhi_last", outv, FWD ? 8'b1100_0111 : 8'b0001_0110);
      else         cmp($sformatf("div_mfhi_k%0d", k), outv, 8'b0001_0100);
    end
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 0, 0);
    #1;
    cmp("div_mfhi_release", outv, 8'b1100_0000);

    // Back-to-back MULTs: the second holds in ID until the cycle after completion.
    reset_pulse();
    @(negedge clk);
    drive(0, 1, 0, 0, 0, 0, 0);
    #1;
    cmp("b2b_first_issue", outv, 8'b1100_1000);
    for (int k = 1; k <= ML; k++) begin
      @(negedge clk);
      #1;
      cmp($sformatf("b2b_stall_k%0d", k), outv, {7'b0001_010, 1'b0} | ((k == ML) ? 8'b0000_0010 : 8'b0));
    end
    @(negedge clk);
    #1;
    cmp("b2b_second_issue", outv, 8'b1100_1000);
    t_we = 0;
    for (int k = 1; k <= ML; k++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0);
      #1;
      if (hilo_we) t_we = k;
    end
    cmp("b2b_second_we_offset", 8'(t_we), 8'(ML));

    // Reset in the middle of a DIV.
    reset_pulse();
    @(negedge clk);
    drive(0, 1, 1, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0);
    end
    #1;
    cmp("mid_div_busy", outv, 8'b1100_0100);
    #3;
    drive(1, 0, 0, 0, 0, 1, 0);
    #1;
    cmp("mid_div_async_reset", outv, 8'b1100_0000);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    t_we = 0;
    for (int k = 0; k < DL + 2; k++) begin
      @(negedge clk);
      #1;
      if (hilo_we || mdu_busy) t_we++;
    end
    cmp("post_reset_no_we", 8'(t_we), 8'd0);
    @(negedge clk);
    drive(0, 1, 0, 0, 0, 0, 0);
    #1;
    cmp("post_reset_mult_issue", outv, 8'b1100_1000);

    // Randomized run against the reference model.
    reset_pulse();
    m_active = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      drive(($urandom % 150) == 0, ($urandom % 3) == 0, ($urandom % 4) == 0,
            ($urandom % 5) == 0, ($urandom % 8) == 0, ($urandom % 6) == 0,
            ($urandom % 8) == 0);
      #1;
      model_step(e);
      cmp($sformatf("rand_cyc%0d", n), outv, e);
      cyc++;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
